// File: rtl/seg_led_decoder_pkg.sv
// Shared constants, glyph decoder and FSM encoding for the seven-segment bus monitor.
package seg_led_pkg;

    localparam int NUM_DIGITS = 6;

    // Active-high a..g glyphs
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_e;

    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [3:0] hex;
    } glyph_t;

    function automatic glyph_t seg_decode(input logic [6:0] s);
        glyph_t g;
        g.legal = 1'b1;
        g.blank = 1'b0;
        g.hex   = 4'h0;
        case (s)
            SEG_0:     g.hex = 4'h0;
            SEG_1:     g.hex = 4'h1;
            SEG_2:     g.hex = 4'h2;
            SEG_3:     g.hex = 4'h3;
            SEG_4:     g.hex = 4'h4;
            SEG_5:     g.hex = 4'h5;
            SEG_6:     g.hex = 4'h6;
            SEG_7:     g.hex = 4'h7;
            SEG_8:     g.hex = 4'h8;
            SEG_9:     g.hex = 4'h9;
            SEG_A:     g.hex = 4'hA;
            SEG_B:     g.hex = 4'hB;
            SEG_C:     g.hex = 4'hC;
            SEG_D:     g.hex = 4'hD;
            SEG_E:     g.hex = 4'hE;
            SEG_F:     g.hex = 4'hF;
            SEG_BLANK: g.blank = 1'b1;
            default:   g.legal = 1'b0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg_led_decoder_if.sv
// Display bus (sel/seg) plus the decoded view produced by the monitor.
interface seg_led_decoder_if;
    logic [5:0]  sel;
    logic [7:0]  seg;
    logic [23:0] digits;
    logic [5:0]  dp;
    logic [5:0]  blank;
    logic [5:0]  digit_valid;
    logic        frame_done;
    logic        pat_err;

    modport master (
        output sel, seg,
        input  digits, dp, blank, digit_valid, frame_done, pat_err
    );

    modport slave (
        input  sel, seg,
        output digits, dp, blank, digit_valid, frame_done, pat_err
    );
endinterface

// File: rtl/seg_age_timer.sv
// Per-digit refresh age counter; flags expiry once TIMEOUT_CYC-1 cycles pass without refresh.
module seg_age_timer #(
    parameter int TIMEOUT_CYC = 2_500_000
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic refresh,
    input  logic valid_set,
    input  logic valid,
    output logic expired
);

    localparam int AGE_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT_CYC - 1);

    logic [AGE_W-1:0] age;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            age <= '0;
        end else if (refresh || valid_set) begin
            age <= '0;
        end else if (valid && (age != AGE_MAX)) begin
            age <= age + 1'b1;
        end
    end

    // A refresh landing on the expiry cycle keeps the digit alive
    assign expired = valid && (age == AGE_MAX) && !refresh && !valid_set;

endmodule

// File: rtl/seg_led_decoder.sv
// Passive seven-segment bus monitor: settles sel/seg, decodes glyphs per digit, ages stale digits.
module seg_led_decoder
    import seg_led_pkg::*;
#(
    parameter int SEL_ACT_LOW = 1,
    parameter int SEG_ACT_LOW = 1,
    parameter int STABLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 2_500_000
) (
    input logic              sys_clk,
    input logic              rst,
    seg_led_decoder_if.slave bus
);

    localparam int CNT_W = $clog2(STABLE_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [5:0] SEL_IDLE = (SEL_ACT_LOW != 0) ? 6'h3F : 6'h00;
    localparam logic [7:0] SEG_IDLE = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_SETTLE  = SETTLE;
    localparam logic [1:0] ST_CAPTURE = CAPTURE;
    localparam logic [1:0] ST_HOLD    = HOLD;

    logic [5:0]       sel_p0, sel_p1;
    logic [7:0]       seg_p0, seg_p1;
    logic [5:0]       sel_n;
    logic [7:0]       seg_n;
    logic [1:0]       state;
    logic [5:0]       ref_sel;
    logic [7:0]       ref_seg;
    logic [CNT_W-1:0] stab_cnt;
    logic [5:0]       seen;
    logic [23:0]      digits_q;
    logic [5:0]       dp_q, blank_q, valid_q;
    logic             frame_q, pat_err_q;
    logic             bus_eq, bus_idle;
    glyph_t           glyph;
    logic [5:0]       cap_wr, hold_ref, expired;

    // Stage p0/p1: synchroniser, idle level held during reset so nothing looks active
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sel_p0 <= SEL_IDLE;
            sel_p1 <= SEL_IDLE;
            seg_p0 <= SEG_IDLE;
            seg_p1 <= SEG_IDLE;
        end else begin
            sel_p0 <= bus.sel;
            sel_p1 <= sel_p0;
            seg_p0 <= bus.seg;
            seg_p1 <= seg_p0;
        end
    end

    assign sel_n    = sel_p1 ^ SEL_IDLE;
    assign seg_n    = seg_p1 ^ SEG_IDLE;
    assign bus_idle = (sel_n == 6'h00);
    assign bus_eq   = (sel_n == ref_sel) && (seg_n == ref_seg);
    assign glyph    = seg_decode(ref_seg[6:0]);

    assign cap_wr   = ((state == ST_CAPTURE) && glyph.legal) ? ref_sel : 6'h00;
    assign hold_ref = ((state == ST_HOLD) && !bus_idle && bus_eq && glyph.legal) ? ref_sel : 6'h00;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ref_sel  <= '0;
            ref_seg  <= '0;
            stab_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!bus_idle) begin
                        state    <= ST_SETTLE;
                        ref_sel  <= sel_n;
                        ref_seg  <= seg_n;
                        stab_cnt <= CNT_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (bus_idle) begin
                        state <= ST_IDLE;
                    end else if (!bus_eq) begin
                        ref_sel  <= sel_n;
                        ref_seg  <= seg_n;
                        stab_cnt <= CNT_W'(1);
                    end else if (stab_cnt == CNT_LAST) begin
                        state <= ST_CAPTURE;
                    end else begin
                        stab_cnt <= stab_cnt + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    state <= ST_HOLD;
                end
                default: begin
                    if (bus_idle) begin
                        state <= ST_IDLE;
                    end else if (!bus_eq) begin
                        state    <= ST_SETTLE;
                        ref_sel  <= sel_n;
                        ref_seg  <= seg_n;
                        stab_cnt <= CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Capture stage: digit registers, frame tracking and error pulse
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            digits_q  <= '0;
            dp_q      <= '0;
            blank_q   <= '0;
            valid_q   <= '0;
            seen      <= '0;
            frame_q   <= 1'b0;
            pat_err_q <= 1'b0;
        end else begin
            frame_q   <= 1'b0;
            pat_err_q <= 1'b0;
            if (state == ST_CAPTURE) begin
                if (!glyph.legal) begin
                    pat_err_q <= 1'b1;
                end else if ((seen | ref_sel) == 6'h3F) begin
                    frame_q <= 1'b1;
                    seen    <= '0;
                end else begin
                    seen <= seen | ref_sel;
                end
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (cap_wr[i]) begin
                    digits_q[4*i +: 4] <= glyph.hex;
                    dp_q[i]            <= ref_seg[7];
                    blank_q[i]         <= glyph.blank;
                    valid_q[i]         <= 1'b1;
                end else if (expired[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_age
        seg_age_timer #(
            .TIMEOUT_CYC(TIMEOUT_CYC)
        ) u_age (
            .sys_clk  (sys_clk),
            .rst      (rst),
            .refresh  (hold_ref[i]),
            .valid_set(cap_wr[i]),
            .valid    (valid_q[i]),
            .expired  (expired[i])
        );
    end

    assign bus.digits      = digits_q;
    assign bus.dp          = dp_q;
    assign bus.blank       = blank_q;
    assign bus.digit_valid = valid_q;
    assign bus.frame_done  = frame_q;
    assign bus.pat_err     = pat_err_q;

endmodule
